// File: rtl/wb_commit_ctrl_pkg.sv
// Shared widths, load funct3 codes, FSM states and the captured-load record
// for the write-back commit stage.
package wb_commit_ctrl_pkg;
  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CSR_ADDR_WIDTH = 12;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_LOAD_WAIT = 1'b1
  } wb_state_e;

  // Everything a load needs to remember while the memory response is pending.
  typedef struct packed {
    logic                      reg_en;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic [2:0]                funct3;
    logic [1:0]                addr_lo;
    logic                      csr_en;
    logic [CSR_ADDR_WIDTH-1:0] csr_addr;
    logic [CPU_WIDTH-1:0]      csr_data;
  } load_cap_t;
endpackage

// File: rtl/wb_commit_ctrl_load_extend.sv
// Load extension: selects byte/half from an aligned word and sign/zero-extends it.
module wb_commit_ctrl_load_extend
  import wb_commit_ctrl_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [CPU_WIDTH-1:0] word,
  output logic [CPU_WIDTH-1:0] data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // Halfword loads ignore bit 0 of the offset.
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      F3_LW:   data = word;
      default: data = word;
    endcase
  end
endmodule

// File: rtl/wb_commit_ctrl.sv
// Write-back commit stage: registers ALU/CSR results and resolves pending loads,
// stalling upstream while a load response is outstanding.
module wb_commit_ctrl
  import wb_commit_ctrl_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 15,
  parameter int CNT_W        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      as_valid_i,
  input  logic                      as_reg_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] as_reg_wr_adder_i,
  input  logic [CPU_WIDTH-1:0]      as_reg_wr_data_i,
  input  logic                      as_csr_wr_en_i,
  input  logic [CSR_ADDR_WIDTH-1:0] as_csr_wr_adder_i,
  input  logic [CPU_WIDTH-1:0]      as_csr_wr_data_i,
  input  logic                      as_mem_rd_en_i,
  input  logic [2:0]                as_mem_funct3_i,
  input  logic [1:0]                as_mem_addr_lo_i,
  input  logic                      dmem_rd_valid_i,
  input  logic [CPU_WIDTH-1:0]      dmem_rd_data_i,
  input  logic                      flush_i,
  output logic                      wb_reg_wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_wr_adder_o,
  output logic [CPU_WIDTH-1:0]      wb_reg_wr_data_o,
  output logic                      wb_csr_wr_en_o,
  output logic [CSR_ADDR_WIDTH-1:0] wb_csr_wr_adder_o,
  output logic [CPU_WIDTH-1:0]      wb_csr_wr_data_o,
  output logic                      wb_busy_o,
  output logic                      load_fault_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e            state;
  logic [CNT_W-1:0]     cnt;
  load_cap_t            cap;
  logic [CPU_WIDTH-1:0] load_data;

  wb_commit_ctrl_load_extend u_ext (
    .funct3  (cap.funct3),
    .addr_lo (cap.addr_lo),
    .word    (dmem_rd_data_i),
    .data    (load_data)
  );

  assign wb_busy_o = (state == WB_LOAD_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= WB_IDLE;
      cnt               <= '0;
      cap               <= '0;
      wb_reg_wr_en_o    <= 1'b0;
      wb_reg_wr_adder_o <= '0;
      wb_reg_wr_data_o  <= '0;
      wb_csr_wr_en_o    <= 1'b0;
      wb_csr_wr_adder_o <= '0;
      wb_csr_wr_data_o  <= '0;
      load_fault_o      <= 1'b0;
    end else begin
      wb_reg_wr_en_o <= 1'b0;
      wb_csr_wr_en_o <= 1'b0;
      load_fault_o   <= 1'b0;
      if (flush_i) begin
        state <= WB_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          WB_IDLE: if (as_valid_i) begin
            if (as_mem_rd_en_i) begin
              cap   <= '{reg_en: as_reg_wr_en_i, reg_addr: as_reg_wr_adder_i,
                         funct3: as_mem_funct3_i, addr_lo: as_mem_addr_lo_i,
                         csr_en: as_csr_wr_en_i, csr_addr: as_csr_wr_adder_i,
                         csr_data: as_csr_wr_data_i};
              state <= WB_LOAD_WAIT;
              cnt   <= '0;
            end else begin
              // Address/data only move with their strobe so the buses hold otherwise.
              if (as_reg_wr_en_i && as_reg_wr_adder_i != '0) begin
                wb_reg_wr_en_o    <= 1'b1;
                wb_reg_wr_adder_o <= as_reg_wr_adder_i;
                wb_reg_wr_data_o  <= as_reg_wr_data_i;
              end
              if (as_csr_wr_en_i) begin
                wb_csr_wr_en_o    <= 1'b1;
                wb_csr_wr_adder_o <= as_csr_wr_adder_i;
                wb_csr_wr_data_o  <= as_csr_wr_data_i;
              end
            end
          end
          WB_LOAD_WAIT: begin
            // A response on the last wait cycle still commits rather than faulting.
            if (dmem_rd_valid_i) begin
              if (cap.reg_en && cap.reg_addr != '0) begin
                wb_reg_wr_en_o    <= 1'b1;
                wb_reg_wr_adder_o <= cap.reg_addr;
                wb_reg_wr_data_o  <= load_data;
              end
              if (cap.csr_en) begin
                wb_csr_wr_en_o    <= 1'b1;
                wb_csr_wr_adder_o <= cap.csr_addr;
                wb_csr_wr_data_o  <= cap.csr_data;
              end
              state <= WB_IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              load_fault_o <= 1'b1;
              state        <= WB_IDLE;
              cnt          <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= WB_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Randomized scoreboard bench for wb_commit_ctrl: drivers push expected commits,
// a monitor pops and compares whenever a strobe or fault appears.
module tb_wb_commit_ctrl;
  localparam int LOAD_TIMEOUT = 15;

  logic        clk, rst;
  logic        as_valid, as_reg_wr_en, as_csr_wr_en, as_mem_rd_en;
  logic [4:0]  as_reg_wr_adder;
  logic [31:0] as_reg_wr_data, as_csr_wr_data, dmem_rd_data;
  logic [11:0] as_csr_wr_adder;
  logic [2:0]  as_mem_funct3;
  logic [1:0]  as_mem_addr_lo;
  logic        dmem_rd_valid, flush;
  logic        wb_reg_wr_en, wb_csr_wr_en, wb_busy, load_fault;
  logic [4:0]  wb_reg_wr_adder;
  logic [31:0] wb_reg_wr_data, wb_csr_wr_data;
  logic [11:0] wb_csr_wr_adder;

  wb_commit_ctrl #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .as_valid_i(as_valid), .as_reg_wr_en_i(as_reg_wr_en),
    .as_reg_wr_adder_i(as_reg_wr_adder), .as_reg_wr_data_i(as_reg_wr_data),
    .as_csr_wr_en_i(as_csr_wr_en), .as_csr_wr_adder_i(as_csr_wr_adder),
    .as_csr_wr_data_i(as_csr_wr_data), .as_mem_rd_en_i(as_mem_rd_en),
    .as_mem_funct3_i(as_mem_funct3), .as_mem_addr_lo_i(as_mem_addr_lo),
    .dmem_rd_valid_i(dmem_rd_valid), .dmem_rd_data_i(dmem_rd_data),
    .flush_i(flush),
    .wb_reg_wr_en_o(wb_reg_wr_en), .wb_reg_wr_adder_o(wb_reg_wr_adder),
    .wb_reg_wr_data_o(wb_reg_wr_data), .wb_csr_wr_en_o(wb_csr_wr_en),
    .wb_csr_wr_adder_o(wb_csr_wr_adder), .wb_csr_wr_data_o(wb_csr_wr_data),
    .wb_busy_o(wb_busy), .load_fault_o(load_fault)
  );

  typedef struct {
    int          cyc;
    logic        reg_en;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        csr_en;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        fault;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference load result from the architectural rules, not the RTL structure.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lo, input logic [31:0] w);
    int unsigned v;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (lo * 8)) & 32'hFF;
        if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (w >> ((lo / 2) * 16)) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    as_valid = 0; as_mem_rd_en = 0; flush = 0; dmem_rd_valid = 0;
    as_reg_wr_en = 1'($urandom); as_csr_wr_en = 1'($urandom);
    as_reg_wr_adder = 5'($urandom); as_reg_wr_data = $urandom;
    as_csr_wr_adder = 12'($urandom); as_csr_wr_data = $urandom;
    as_mem_funct3 = 3'($urandom); as_mem_addr_lo = 2'($urandom);
    dmem_rd_data = $urandom;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_reg_en"}, {31'd0, wb_reg_wr_en}, 0);
    chk({nm, "_reg_addr"}, {27'd0, wb_reg_wr_adder}, 0);
    chk({nm, "_reg_data"}, wb_reg_wr_data, 0);
    chk({nm, "_csr_en"}, {31'd0, wb_csr_wr_en}, 0);
    chk({nm, "_csr_addr"}, {20'd0, wb_csr_wr_adder}, 0);
    chk({nm, "_csr_data"}, wb_csr_wr_data, 0);
    chk({nm, "_busy"}, {31'd0, wb_busy}, 0);
    chk({nm, "_fault"}, {31'd0, load_fault}, 0);
  endtask

  task automatic idle_op(input logic re, input logic [4:0] ra, input logic [31:0] rd,
                         input logic ce, input logic [11:0] ca, input logic [31:0] cd,
                         input logic fl, input logic stray);
    ev_t e;
    as_valid = 1; as_mem_rd_en = 0;
    as_reg_wr_en = re; as_reg_wr_adder = ra; as_reg_wr_data = rd;
    as_csr_wr_en = ce; as_csr_wr_adder = ca; as_csr_wr_data = cd;
    flush = fl; dmem_rd_valid = stray; dmem_rd_data = $urandom;
    if (!fl && ((re && ra != 0) || ce)) begin
      e = '{cyc + 1, re && (ra != 0), ra, rd, ce, ca, cd, 1'b0};
      sb.push_back(e);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // dly: wait cycle carrying the response (0 = never); fl_at: wait cycle with flush (0 = none).
  task automatic load_op(input logic [2:0] f3, input logic [1:0] lo, input logic re,
                         input logic [4:0] ra, input logic ce, input logic [11:0] ca,
                         input logic [31:0] cd, input logic [31:0] w, input int dly, input int fl_at);
    ev_t e;
    as_valid = 1; as_mem_rd_en = 1; as_mem_funct3 = f3; as_mem_addr_lo = lo;
    as_reg_wr_en = re; as_reg_wr_adder = ra; as_reg_wr_data = $urandom;
    as_csr_wr_en = ce; as_csr_wr_adder = ca; as_csr_wr_data = cd;
    @(negedge clk);
    for (int wi = 1; wi <= LOAD_TIMEOUT; wi++) begin
      chk("busy_wait", {31'd0, wb_busy}, 1);
      as_valid = 1; as_mem_rd_en = 1'($urandom);
      as_reg_wr_en = 1; as_reg_wr_adder = 5'($urandom); as_reg_wr_data = $urandom;
      as_csr_wr_en = 1'($urandom); as_csr_wr_adder = 12'($urandom);
      dmem_rd_valid = (wi == dly);
      dmem_rd_data  = (wi == dly) ? w : $urandom;
      flush = (wi == fl_at);
      if (wi == fl_at) begin
      end else if (wi == dly) begin
        if ((re && ra != 0) || ce) begin
          e = '{cyc + 1, re && (ra != 0), ra, ref_load(f3, int'(lo), w), ce, ca, cd, 1'b0};
          sb.push_back(e);
        end
      end else if (wi == LOAD_TIMEOUT) begin
        e = '{cyc + 1, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1};
        sb.push_back(e);
      end
      @(negedge clk);
      if (wi == dly || wi == fl_at) break;
    end
    clear_inputs();
    chk("busy_after", {31'd0, wb_busy}, 0);
  endtask

  ev_t  me;
  logic ok;
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_reg_wr_en || wb_csr_wr_en || load_fault) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_commit cyc=%0d reg=%b csr=%b fault=%b, expected no output",
                   cyc, wb_reg_wr_en, wb_csr_wr_en, load_fault);
        end else begin
          me = sb.pop_front();
          ok = (me.cyc == cyc) && (me.reg_en == wb_reg_wr_en) &&
               (me.csr_en == wb_csr_wr_en) && (me.fault == load_fault);
          if (me.reg_en) ok = ok && (me.ra == wb_reg_wr_adder) && (me.rd == wb_reg_wr_data);
          if (me.csr_en) ok = ok && (me.ca == wb_csr_wr_adder) && (me.cd == wb_csr_wr_data);
          if (!ok) begin
            n_bad++;
            $display("FAIL commit got cyc=%0d reg=%b %0d %h csr=%b %h %h fault=%b; want cyc=%0d reg=%b %0d %h csr=%b %h %h fault=%b",
                     cyc, wb_reg_wr_en, wb_reg_wr_adder, wb_reg_wr_data, wb_csr_wr_en,
                     wb_csr_wr_adder, wb_csr_wr_data, load_fault, me.cyc, me.reg_en, me.ra,
                     me.rd, me.csr_en, me.ca, me.cd, me.fault);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_commit at cyc=%0d: no output, want reg=%b %0d %h csr=%b fault=%b",
                 cyc, sb[0].reg_en, sb[0].ra, sb[0].rd, sb[0].csr_en, sb[0].fault);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, r, dly, fl_at;
    rst = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    check_all_zero("in_reset");
    rst = 0;
    @(negedge clk);
    check_all_zero("after_reset");

    idle_op(1, 5'd5, 32'h1234, 0, 12'h0, 32'h0, 0, 0);
    chk("busy_alu", {31'd0, wb_busy}, 0);
    idle_op(1, 5'd0, 32'hFFFF, 1, 12'h300, 32'h8, 0, 0);

    load_op(3'b000, 2'd3, 1, 5'd7,  0, 12'h0, 32'h0, 32'h80FF7F01, 3, 0);
    load_op(3'b100, 2'd1, 1, 5'd8,  0, 12'h0, 32'h0, 32'h80FF7F01, 3, 0);
    load_op(3'b001, 2'd2, 1, 5'd9,  0, 12'h0, 32'h0, 32'h80FF7F01, 3, 0);
    load_op(3'b010, 2'd0, 1, 5'd10, 0, 12'h0, 32'h0, 32'h80FF7F01, 3, 0);
    load_op(3'b101, 2'd3, 1, 5'd11, 1, 12'h341, 32'hCAFE, 32'h80FF7F01, 1, 0);
    load_op(3'b011, 2'd2, 1, 5'd12, 0, 12'h0, 32'h0, 32'h1357_9BDF, 2, 0);

    load_op(3'b010, 2'd0, 1, 5'd3, 0, 12'h0, 32'h0, 32'h0, 0, 0);
    load_op(3'b000, 2'd0, 1, 5'd4, 0, 12'h0, 32'h0, 32'h0000_00F0, 15, 0);
    load_op(3'b010, 2'd0, 1, 5'd6, 1, 12'h305, 32'h55, 32'hDEAD_BEEF, 2, 2);
    idle_op(1, 5'd13, 32'h77, 1, 12'h7, 32'h9, 1, 0);
    idle_op(1, 5'd14, 32'h88, 0, 12'h0, 32'h0, 0, 1);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        idle_op(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 12'($urandom),
                $urandom, ($urandom_range(0, 9) == 0), 1'($urandom));
      end else if (k == 4) begin
        clear_inputs();
        @(negedge clk);
      end else begin
        r     = $urandom_range(0, 19);
        dly   = (r > LOAD_TIMEOUT) ? 0 : r;
        fl_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, LOAD_TIMEOUT) : 0;
        load_op(3'($urandom), 2'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
                12'($urandom), $urandom, $urandom, dly, fl_at);
      end
    end

    idle_op(1, 5'd21, 32'hA5A5_0001, 1, 12'h123, 32'h0BAD, 0, 0);
    as_valid = 1; as_mem_rd_en = 1; as_reg_wr_en = 1; as_reg_wr_adder = 5'd22;
    as_mem_funct3 = 3'b010; as_csr_wr_en = 1;
    @(negedge clk);
    clear_inputs();
    chk("busy_before_rst", {31'd0, wb_busy}, 1);
    rst = 1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    dmem_rd_valid = 1;
    @(negedge clk);
    rst = 0;
    dmem_rd_valid = 0;
    repeat (3) @(negedge clk);
    check_all_zero("post_rst");

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_commit_ctrl.md
Name: wb_commit_ctrl

Overview:
- Write-back commit stage: the write end of the operand-forwarding interface. It registers access-stage results and resolves pending data-memory loads.
- Drives the wb_reg_wr_* and wb_csr_wr_* buses consumed by the register file, the CSR file and the forwarding unit.
- Holds the pipeline via wb_busy_o while a load response is outstanding.

Parameters:
- LOAD_TIMEOUT, 15, maximum cycles in LOAD_WAIT before a load fault is raised.
- CNT_W, 4, wait-counter width; must satisfy 2^CNT_W > LOAD_TIMEOUT.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-high.
- as_valid_i  in  1  access stage presents an instruction this cycle.
- as_reg_wr_en_i  in  1  instruction writes a GPR.
- as_reg_wr_adder_i  in  `REG_ADDR_WIDTH  destination GPR.
- as_reg_wr_data_i  in  `CPU_WIDTH  ALU result (ignored for loads).
- as_csr_wr_en_i  in  1  instruction writes a CSR.
- as_csr_wr_adder_i  in  `CSR_ADDR_WIDTH  destination CSR.
- as_csr_wr_data_i  in  `CPU_WIDTH  CSR write value.
- as_mem_rd_en_i  in  1  instruction is a load.
- as_mem_funct3_i  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- as_mem_addr_lo_i  in  2  byte offset of the load address.
- dmem_rd_valid_i  in  1  load data valid.
- dmem_rd_data_i  in  `CPU_WIDTH  aligned 32-bit memory word.
- flush_i  in  1  discard any uncommitted instruction.
- wb_reg_wr_en_o  out  1  GPR write strobe.
- wb_reg_wr_adder_o  out  `REG_ADDR_WIDTH  GPR address.
- wb_reg_wr_data_o  out  `CPU_WIDTH  GPR data.
- wb_csr_wr_en_o  out  1  CSR write strobe.
- wb_csr_wr_adder_o  out  `CSR_ADDR_WIDTH  CSR address.
- wb_csr_wr_data_o  out  `CPU_WIDTH  CSR data.
- wb_busy_o  out  1  stall request to upstream stages.
- load_fault_o  out  1  one-cycle pulse on load timeout.

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0; captured fields cleared.
- Write strobes are one-cycle pulses. Address and data outputs hold their last value while strobes are low.
- IDLE, as_valid_i=1, as_mem_rd_en_i=0:
  - Next edge: wb_reg_wr_en_o = as_reg_wr_en_i AND (addr != 0), with addr/data copied.
  - CSR bus copied likewise, with no x0-style suppression.
  - Latency 1 cycle.
- IDLE, as_valid_i=1, as_mem_rd_en_i=1:
  - Capture reg_wr_en, reg_wr_adder, funct3, addr_lo and any CSR fields; go to LOAD_WAIT; counter=0.
  - No strobe this edge.
- LOAD_WAIT:
  - wb_busy_o=1, driven combinationally from the state.
  - as_valid_i is ignored; upstream holds its instruction.
- LOAD_WAIT, dmem_rd_valid_i=1:
  - Extract byte/half at addr_lo; sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the whole word.
  - LH/LHU use addr_lo[1] only.
  - Next edge: GPR strobe with the extracted data (suppressed for x0); captured CSR write committed in the same cycle; return to IDLE.
  - Minimum load latency is 1 cycle after entry; dmem_rd_valid_i is sampled from the first LOAD_WAIT cycle.
- LOAD_WAIT, no valid: counter increments. If counter == LOAD_TIMEOUT-1 and no valid, the next edge pulses load_fault_o, makes no write and returns to IDLE.
- Valid arriving on the timeout cycle: the valid wins; commit normally, no fault.
- Reserved funct3 (011, 11x): treated as LW.
- flush_i (highest priority after reset):
  - Next edge: all strobes 0, state IDLE, counter 0.
  - An as_valid_i in the same cycle is dropped.
  - A dmem_rd_valid_i in the same cycle is discarded.
- dmem_rd_valid_i in IDLE is ignored.
- Reset asserted mid-LOAD_WAIT: outputs clear immediately (async); no fault and no write.

Decomposition:
- rooth_defines.v: add LOAD funct3 codes (`LB`, `LH`, `LW`, `LBU`, `LHU`) and state encodings `WB_IDLE`/`WB_LOAD_WAIT`; reuse the existing width macros.
- One sub-module, load_extend: combinational (funct3, addr_lo, word) -> extended 32-bit data.
- FSM, counter and output registers stay in wb_commit_ctrl.

Test Plan:
- ALU write: as_valid=1, reg_wr_en=1, addr=5, data=0x1234 -> next cycle wb_reg_wr_en_o=1, addr 5, data 0x1234; busy stays 0.
- x0 suppression plus CSR: addr=0, data=0xFFFF, csr_wr_en=1, csr 0x300, data 0x8 -> wb_reg_wr_en_o=0; wb_csr_wr_en_o=1 to 0x300 with 0x8.
- Loads, all using dmem word 0x80FF7F01 delivered after 3 cycles (busy=1 for exactly 3 cycles, then one strobe):
  - LB, addr_lo=3 -> 0xFFFFFF80.
  - LBU, addr_lo=1 -> 0x0000007F.
  - LH, addr_lo=2 -> 0xFFFF80FF.
  - LW -> 0x80FF7F01.
- Timeout: load issued, no dmem valid -> after 15 cycles load_fault_o pulses once, no write, busy=0.
- Timeout boundary: valid on the 15th wait cycle -> normal write, no fault.
- Flush mid-load: flush_i at wait cycle 2 with valid in the same cycle -> no write, IDLE next cycle. Separately, reset at wait cycle 1 -> all outputs 0 immediately.
